// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants.
// Used by the PRGA side and the keystream consumer.
package rc4_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      RUN   = 1'b0,
      ERROR = 1'b1
   } state_t;

   localparam int RC4_DISCARD = 1536;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Synchronous byte FIFO with occupancy output.
// A push into a full FIFO is accepted when a pop happens the same cycle.
module rc4_ks_fifo
   import rc4_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  byte_t                      din_i,
   output byte_t                      dout_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       push_ok_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [LW-1:0] lvl_q;
   logic [LW-1:0] lvl_d;
   byte_t         mem_q [DEPTH];
   logic          pop;
   logic          full;

   assign full      = (lvl_q == LW'(DEPTH));
   assign pop       = pop_i && (lvl_q != '0);
   assign push_ok_o = push_i && (!full || pop);
   assign dout_o    = mem_q[rd_q];
   assign level_o   = lvl_q;

   // Occupancy next-state from push/pop pair.
   always_comb begin
      lvl_d = lvl_q;
      unique case ({push_ok_o, pop})
         2'b10:   lvl_d = lvl_q + LW'(1);
         2'b01:   lvl_d = lvl_q - LW'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   // Pointers and occupancy; pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (push_ok_o) wr_q <= wr_q + AW'(1);
         if (pop)       rd_q <= rd_q + AW'(1);
         lvl_q <= lvl_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_o) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/rc4_keystream_xor.sv
// Buffers PRGA keystream and XORs it onto a host byte stream.
// Keystream loss locks the block into ERROR until reset.
module rc4_keystream_xor
   import rc4_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ks_valid,
   input  logic [7:0]             ks_byte,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_data,
   output logic                   out_last,
   output logic [$clog2(DEPTH):0] ks_level,
   output logic                   overflow,
   output logic [CNT_W-1:0]       byte_count,
   output logic                   msg_done
);

   state_t           state_q;
   logic             overflow_q;
   logic             out_valid_q;
   byte_t            out_data_q;
   logic             out_last_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [CNT_W-1:0] byte_cnt_d;
   logic             msg_done_q;
   logic             msg_done_d;

   byte_t head;
   logic  push_req;
   logic  push_ok;
   logic  accept;
   logic  hs;

   assign push_req = ks_valid && (state_q == RUN);
   assign in_ready = (state_q == RUN) && (ks_level != '0)
                  && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign hs       = out_valid_q && out_ready;

   assign byte_cnt_d = byte_cnt_q + CNT_W'(hs);
   assign msg_done_d = hs && out_last_q;

   rc4_ks_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push_req),
      .pop_i     (accept),
      .din_i     (ks_byte),
      .dout_o    (head),
      .level_o   (ks_level),
      .push_ok_o (push_ok)
   );

   // RUN/ERROR state; a refused keystream push is fatal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         overflow_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (push_req && !push_ok) begin
                  state_q    <= ERROR;
                  overflow_q <= 1'b1;
               end
            end
            ERROR: begin
               state_q    <= ERROR;
               overflow_q <= 1'b1;
            end
            default: begin
               state_q    <= ERROR;
               overflow_q <= 1'b1;
            end
         endcase
      end
   end

   // Output register: load on accept, clear after handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= in_data ^ head;
         out_last_q  <= in_last;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Emitted-byte counter and end-of-message pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_q <= '0;
         msg_done_q <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         msg_done_q <= msg_done_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign overflow   = overflow_q;
   assign byte_count = byte_cnt_q;
   assign msg_done   = msg_done_q;

endmodule

// File: tb/tb_rc4_keystream_xor.sv
// Bench for rc4_keystream_xor: keystream queue model plus
// scoreboard of expected output bytes.
module tb_rc4_keystream_xor;

   localparam int DEPTH = 16;
   localparam int CNT_W = 32;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ks_valid = 1'b0;
   logic [7:0]       ks_byte = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_data;
   logic             out_last;
   logic [LW-1:0]    ks_level;
   logic             overflow;
   logic [CNT_W-1:0] byte_count;
   logic             msg_done;

   rc4_keystream_xor #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ks_valid   (ks_valid),
      .ks_byte    (ks_byte),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .ks_level   (ks_level),
      .overflow   (overflow),
      .byte_count (byte_count),
      .msg_done   (msg_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } exp_t;

   int vectors = 0;
   int errors  = 0;

   // Reference model state.
   logic [7:0] ksq [$];
   exp_t       sb  [$];
   bit         err_m = 1'b0;
   bit         ov_m  = 1'b0;
   logic [31:0] cnt_m = '0;
   bit         md_m  = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   // Model: keystream FIFO as a queue, error flag, output-valid.
   always @(negedge clk) begin
      bit   rdy;
      bit   acc;
      if (rst) begin
         ksq.delete();
         sb.delete();
         err_m = 1'b0;
         ov_m  = 1'b0;
      end else begin
         rdy = !err_m && (ksq.size() != 0) && (!ov_m || out_ready);
         chk("level", 32'(ks_level), 32'(ksq.size()));
         chk("overflow", 32'(overflow), 32'(err_m));
         chk("out_valid", 32'(out_valid), 32'(ov_m));
         chk("in_ready", 32'(in_ready), 32'(rdy));
         acc = in_valid && rdy;
         if (acc) begin
            exp_t e;
            e.d = in_data ^ ksq.pop_front();
            e.l = in_last;
            sb.push_back(e);
            ov_m = 1'b1;
         end else if (out_ready) begin
            ov_m = 1'b0;
         end
         if (ks_valid && !err_m) begin
            if (ksq.size() < DEPTH) ksq.push_back(ks_byte);
            else err_m = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         cnt_m = '0;
         md_m  = 1'b0;
      end else begin
         chk("byte_count", byte_count, cnt_m);
         chk("msg_done", 32'(msg_done), 32'(md_m));
         md_m = 1'b0;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_last", 32'(out_last), 32'(e.l));
               md_m = e.l;
            end
            cnt_m = cnt_m + 32'd1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ks_valid  = 1'b0;
      ks_byte   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_level", 32'(ks_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_count", byte_count, 32'd0);
      chk("rst_msg_done", 32'(msg_done), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push_n(int n);
      ks_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         ks_byte = 8'($urandom);
         step();
      end
      ks_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] f;
      logic [7:0] d;
      logic [7:0] held;
      int         pulses;

      #1;
      do_reset();

      // 1: basic XOR with known bytes.
      ks_valid = 1'b1;
      ks_byte  = 8'hA5;
      step();
      ks_byte  = 8'h3C;
      step();
      ks_valid = 1'b0;
      chk("t1_level2", 32'(ks_level), 32'd2);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      step();
      chk("t1_d0", 32'(out_data), 32'h5A);
      in_data = 8'h00;
      step();
      chk("t1_d1", 32'(out_data), 32'h3C);
      in_valid = 1'b0;
      step();
      chk("t1_count", byte_count, 32'd2);
      chk("t1_level0", 32'(ks_level), 32'd0);

      // 2: backpressure holds output stable.
      do_reset();
      push_n(3);
      chk("t2_level3", 32'(ks_level), 32'd3);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
      chk("t2_ov", 32'(out_valid), 32'd1);
      chk("t2_rdy0", 32'(in_ready), 32'd0);
      held    = out_data;
      in_data = 8'($urandom);
      step();
      chk("t2_stable", 32'(out_data), 32'(held));
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("t2_count", byte_count, 32'd2);
      chk("t2_level1", 32'(ks_level), 32'd1);

      // 3: overflow locks the block.
      do_reset();
      push_n(DEPTH);
      chk("t3_full_noovf", 32'(overflow), 32'd0);
      push_n(1);
      chk("t3_ovf", 32'(overflow), 32'd1);
      chk("t3_rdy", 32'(in_ready), 32'd0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      ks_valid  = 1'b1;
      step();
      step();
      chk("t3_frozen", 32'(ks_level), 32'(DEPTH));
      chk("t3_ov0", 32'(out_valid), 32'd0);
      do_reset();
      chk("t3_recover", 32'(overflow), 32'd0);

      // 4: push into full FIFO with simultaneous pop.
      ks_valid = 1'b1;
      f        = 8'($urandom);
      ks_byte  = f;
      step();
      push_n(DEPTH - 1);
      d         = 8'($urandom);
      ks_valid  = 1'b1;
      ks_byte   = 8'($urandom);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b1;
      step();
      idle_inputs();
      out_ready = 1'b1;
      chk("t4_noovf", 32'(overflow), 32'd0);
      chk("t4_level", 32'(ks_level), 32'(DEPTH));
      chk("t4_oldest", 32'(out_data), 32'(f ^ d));
      step();

      // 5: message framing and msg_done pulse.
      do_reset();
      push_n(3);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      pulses    = 0;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'($urandom);
         in_last = (i == 2);
         step();
         chk("t5_last", 32'(out_last), 32'(i == 2));
         pulses += int'(msg_done);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         pulses += int'(msg_done);
      end
      chk("t5_pulses", 32'(pulses), 32'd1);

      // 6: reset mid-stream, then realign.
      do_reset();
      push_n(6);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
      in_valid = 1'b0;
      chk("t6_level5", 32'(ks_level), 32'd5);
      chk("t6_ov", 32'(out_valid), 32'd1);
      do_reset();
      ks_valid = 1'b1;
      f        = 8'($urandom);
      ks_byte  = f;
      step();
      ks_valid  = 1'b0;
      d         = 8'($urandom);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t6_first", 32'(out_data), 32'(f ^ d));
      step();

      // Random traffic with periodic resets.
      for (int seg = 0; seg < 8; seg++) begin
         int pk;
         int pi;
         int po;
         do_reset();
         pk = $urandom_range(20, 70);
         pi = $urandom_range(30, 90);
         po = $urandom_range(30, 95);
         for (int c = 0; c < 400; c++) begin
            ks_valid  = ($urandom_range(0, 99) < pk);
            ks_byte   = 8'($urandom);
            in_valid  = ($urandom_range(0, 99) < pi);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 99) < 20);
            out_ready = ($urandom_range(0, 99) < po);
            step();
         end
      end
      idle_inputs();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
